mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_bus_pkg.sv | 37 +++
 rtl/mem_byte_array.sv | 33 +++
 rtl/mem_responder.sv | 111 +++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: FSM encodings, request payload and address checks.
// Used by both the responder and the initiator-side bus adapter.
package mem_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_req_t;

  // Word offset from the window base; addresses below base wrap to a huge offset.
  function automatic logic [ADDR_W-1:0] word_offset(input logic [ADDR_W-1:0] addr,
                                                    input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] diff;
    diff = addr - base;
    return diff >> 2;
  endfunction

  function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input int unsigned       depth);
    logic [ADDR_W-1:0] woff;
    woff = word_offset(addr, base);
    return (addr[1:0] != 2'b00) || (woff >= ADDR_W'(depth));
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Word-organised storage with per-byte write enables and a registered read port.
// The read register can be cleared so the owner can present zero data.
module mem_byte_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  input  logic             rd_en,
  input  logic             rd_clr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Clear wins over read so stores/errors and reset always show zero data.
  always_ff @(posedge clk) begin
    if (rd_clr)     rdata <= '0;
    else if (rd_en) rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accept, wait WAIT_STATES cycles, respond.
// Memory access happens on the edge entering RESP so response data is registered.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  mem_req_t         req_q, req_nxt, req_in, cur_req;
  logic             enter_resp_c;
  logic             cur_err_c;
  logic             mem_wr_en, mem_rd_en, mem_rd_clr;
  logic [IDX_W-1:0] mem_idx;

  assign req_in = '{write: req_write, addr: req_addr, wdata: req_wdata, be: req_be};

  // With zero wait states the access happens on the accept edge, so use live inputs.
  assign cur_req      = (state == ST_IDLE) ? req_in : req_q;
  assign enter_resp_c = (state != ST_RESP) && (state_nxt == ST_RESP);
  assign cur_err_c    = addr_err(cur_req.addr, BASE_ADDR, DEPTH_WORDS);
  assign mem_idx      = IDX_W'(word_offset(cur_req.addr, BASE_ADDR));

  assign mem_wr_en  = enter_resp_c && !rst && cur_req.write && !cur_err_c;
  assign mem_rd_en  = enter_resp_c && !rst && !cur_req.write && !cur_err_c;
  assign mem_rd_clr = rst || (enter_resp_c && (cur_req.write || cur_err_c));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_nxt   = req_q;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          req_nxt = req_in;
          if (WAIT_STATES == 0) begin
            state_nxt = ST_RESP;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_W'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = ST_RESP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_q     <= req_nxt;
      req_ready <= (state_nxt == ST_IDLE);
      rsp_valid <= (state_nxt == ST_RESP);
      if (enter_resp_c) rsp_err <= cur_err_c;
    end
  end

  mem_byte_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .clk    (clk),
    .wr_en  (mem_wr_en),
    .be     (cur_req.be),
    .idx    (mem_idx),
    .wdata  (cur_req.wdata),
    .rd_en  (mem_rd_en),
    .rd_clr (mem_rd_clr),
    .rdata  (rsp_rdata)
  );

endmodule
